// File: rtl/sysid_boot_checker.sv
// Reads the two sysid words, compares them with build-time values and reports pass/fail/timeout to the boot sequencer.
// Latency: start to done is 5 cycles with a zero-wait slave returning data 1 cycle after acceptance; flags valid 1 cycle later.
// Backpressure: avm_read/avm_address are held stable while avm_waitrequest=1; each transaction is bounded by TIMEOUT_CYCLES.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic        err_timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    // The counter is compared against the last permitted cycle so a transaction gets exactly
    // TIMEOUT_CYCLES cycles (request plus wait) before it is abandoned.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic        auto_pend;
    logic        launch;
    logic        in_txn;
    logic        in_wait;
    logic        tmo_hit;
    logic        req_entry;

    // Next-state decode and Avalon request outputs; request lines depend only on the state
    // register so the asynchronous reset removes avm_read immediately.
    always_comb begin
        state_nxt   = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        launch      = 1'b0;
        in_txn      = 1'b0;
        in_wait     = 1'b0;
        tmo_hit     = 1'b0;
        req_entry   = 1'b0;

        in_txn  = (state == ID_REQ) || (state == ID_WAIT) || (state == TS_REQ) || (state == TS_WAIT);
        in_wait = (state == ID_WAIT) || (state == TS_WAIT);
        // Data arriving in the final permitted cycle still counts as a successful read.
        tmo_hit = in_txn && (tmo_cnt == TMO_LAST) && !(in_wait && avm_readdatavalid);

        case (state)
            IDLE: begin
                launch = start || auto_pend;
                if (launch) begin
                    state_nxt = ID_REQ;
                end
            end
            ID_REQ: begin
                avm_read    = 1'b1;
                avm_address = 1'b0;
                if (tmo_hit) begin
                    state_nxt = IDLE;
                end else if (!avm_waitrequest) begin
                    state_nxt = ID_WAIT;
                end
            end
            ID_WAIT: begin
                if (avm_readdatavalid) begin
                    state_nxt = TS_REQ;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            TS_REQ: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (tmo_hit) begin
                    state_nxt = IDLE;
                end else if (!avm_waitrequest) begin
                    state_nxt = TS_WAIT;
                end
            end
            TS_WAIT: begin
                if (avm_readdatavalid) begin
                    state_nxt = FINISH;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        req_entry = ((state_nxt == ID_REQ) && (state != ID_REQ)) ||
                    ((state_nxt == TS_REQ) && (state != TS_REQ));
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One-shot request for the automatic check on the first cycle after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_START;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    // Per-transaction cycle counter, restarted whenever a new request phase begins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= 16'd0;
        end else if (req_entry) begin
            tmo_cnt <= 16'd0;
        end else if (in_txn) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end

    // Capture returned words; readdatavalid outside the wait states is ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= 32'd0;
            ts_value <= 32'd0;
        end else begin
            if ((state == ID_WAIT) && avm_readdatavalid) begin
                id_value <= avm_readdata;
            end
            if ((state == TS_WAIT) && avm_readdatavalid) begin
                ts_value <= avm_readdata;
            end
        end
    end

    // Result flags: cleared at launch, evaluated in FINISH, forced to failure on timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            match       <= 1'b0;
            err_timeout <= 1'b0;
        end else if (launch) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            match       <= 1'b0;
            err_timeout <= 1'b0;
        end else if (state == FINISH) begin
            id_ok <= (id_value == EXPECTED_ID);
            ts_ok <= (ts_value == EXPECTED_TS);
            match <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
        end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            match       <= 1'b0;
        end
    end

    // Status outputs registered from the next state: done is high in FINISH (or the cycle after
    // a timeout) and busy is already low in that cycle, so start there is not queued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= (state_nxt == FINISH) || tmo_hit;
            busy <= (state_nxt == ID_REQ) || (state_nxt == ID_WAIT) ||
                    (state_nxt == TS_REQ) || (state_nxt == TS_WAIT);
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h1234_5678;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        match;
    logic        err_timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    // slave behaviour knobs (written only by the stimulus process)
    int          wait_states = 0;
    bit          drop_ts = 1'b0;
    bit          late_req = 1'b0;
    logic [31:0] id_word = 32'h0000_0000;
    logic [31:0] ts_word = 32'h1234_5678;

    // slave internal state
    int stall = 0;
    bit acc_pend = 1'b0;
    bit acc_addr = 1'b0;

    sysid_boot_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(8),
        .AUTO_START    (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .match            (match),
        .err_timeout      (err_timeout),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clock = ~clock;

    // sysid slave: drives inputs on the falling edge for the next rising edge
    always @(negedge clock) begin
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        if (!reset_n) begin
            stall    = 0;
            acc_pend = 1'b0;
            if (late_req) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEAD_BEEF;
            end
        end else begin
            if (acc_pend) begin
                acc_pend = 1'b0;
                if (!(acc_addr && drop_ts)) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = acc_addr ? ts_word : id_word;
                end
            end
            if (avm_read) begin
                if (stall < wait_states) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                end else begin
                    stall    = 0;
                    acc_pend = 1'b1;
                    acc_addr = avm_address;
                end
            end else begin
                stall = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // pulse start for one cycle and wait for done; lat=1 is the cycle after start is sampled
    task automatic run_check(input int budget, output int lat, output bit seen, output logic [3:0] flags_t1);
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        flags_t1 = {id_ok, ts_ok, match, err_timeout};
        lat = 1;
        seen = 1'b0;
        while (lat <= budget) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, avm_read, avm_address} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, avm_read, avm_address});
        end
        checks++;
        if ({id_ok, ts_ok, match, err_timeout} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {id_ok, ts_ok, match, err_timeout});
        end
        checks++;
        if ({id_value, ts_value} !== 64'd0) begin
            failures++;
            $display("FAIL reset_values: got %h expected 0", {id_value, ts_value});
        end
        @(negedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_auto_start();
        int  d0;
        int  n;
        bit  seen;
        d0 = done_cnt;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL auto_launch: busy=%b expected 1", busy);
        end
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL auto_done: seen=%b expected 1", seen);
        end
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (match !== 1'b1) begin
            failures++;
            $display("FAIL auto_match: got %b expected 1", match);
        end
        repeat (8) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || (done_cnt - d0) !== 1) begin
            failures++;
            $display("FAIL auto_single_done: busy=%b dones=%0d expected busy=0 dones=1", busy, done_cnt - d0);
        end
    endtask

    task automatic test_match();
        int         lat;
        bit         seen;
        logic [3:0] f1;
        run_check(20, lat, seen, f1);
        checks++;
        if (seen !== 1'b1 || lat !== 5) begin
            failures++;
            $display("FAIL match_latency: seen=%b lat=%0d expected seen=1 lat=5", seen, lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL match_busy_at_done: got %b expected 0", busy);
        end
        @(posedge clock); #1;
        checks++;
        if ({id_ok, ts_ok, match, err_timeout} !== 4'b1110) begin
            failures++;
            $display("FAIL match_flags: got %b expected 1110", {id_ok, ts_ok, match, err_timeout});
        end
        checks++;
        if (id_value !== 32'h0000_0000 || ts_value !== 32'h1234_5678) begin
            failures++;
            $display("FAIL match_values: got %h/%h expected 00000000/12345678", id_value, ts_value);
        end
    endtask

    task automatic test_ts_mismatch();
        int         lat;
        bit         seen;
        logic [3:0] f1;
        ts_word = 32'h1234_5679;
        run_check(20, lat, seen, f1);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL mismatch_done: seen=%b expected 1", seen);
        end
        checks++;
        if (f1 !== 4'b0000) begin
            failures++;
            $display("FAIL launch_clears_flags: got %b expected 0000", f1);
        end
        @(posedge clock); #1;
        checks++;
        if ({id_ok, ts_ok, match, err_timeout} !== 4'b1000) begin
            failures++;
            $display("FAIL mismatch_flags: got %b expected 1000", {id_ok, ts_ok, match, err_timeout});
        end
        checks++;
        if (ts_value !== 32'h1234_5679) begin
            failures++;
            $display("FAIL mismatch_ts_value: got %h expected 12345679", ts_value);
        end
        ts_word = EXP_TS;
    endtask

    task automatic test_wait_states();
        int   lat;
        bit   seen;
        logic exp_rd;
        logic exp_addr;
        wait_states = 3;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (lat <= 30) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            exp_rd   = ((lat >= 1) && (lat <= 4)) || ((lat >= 6) && (lat <= 9));
            exp_addr = (lat >= 6) && (lat <= 9);
            checks++;
            if (avm_read !== exp_rd || (exp_rd && avm_address !== exp_addr)) begin
                failures++;
                $display("FAIL stall_request cycle %0d: read=%b addr=%b expected read=%b addr=%b",
                         lat, avm_read, avm_address, exp_rd, exp_addr);
            end
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (seen !== 1'b1 || lat !== 11) begin
            failures++;
            $display("FAIL stall_latency: seen=%b lat=%0d expected seen=1 lat=11", seen, lat);
        end
        @(posedge clock); #1;
        checks++;
        if (match !== 1'b1) begin
            failures++;
            $display("FAIL stall_match: got %b expected 1", match);
        end
        wait_states = 0;
    endtask

    task automatic test_timeout();
        int         lat;
        bit         seen;
        logic [3:0] f1;
        int         d0;
        drop_ts = 1'b1;
        d0 = done_cnt;
        run_check(40, lat, seen, f1);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL timeout_done: seen=%b expected 1", seen);
        end
        checks++;
        if ({busy, avm_read} !== 2'b00) begin
            failures++;
            $display("FAIL timeout_idle: busy/read=%b expected 00", {busy, avm_read});
        end
        checks++;
        if ({ts_ok, match, err_timeout} !== 3'b001) begin
            failures++;
            $display("FAIL timeout_flags: ts_ok/match/err=%b expected 001", {ts_ok, match, err_timeout});
        end
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if ((done_cnt - d0) !== 1 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_single_done: dones=%0d err=%b expected 1/1", done_cnt - d0, err_timeout);
        end
        drop_ts = 1'b0;
    endtask

    task automatic test_reset_mid();
        int         lat;
        bit         seen;
        logic [3:0] f1;
        int         n;
        drop_ts = 1'b1;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre_busy: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, avm_read, id_ok, ts_ok, match, err_timeout} !== 7'd0 || {id_value, ts_value} !== 64'd0) begin
            failures++;
            $display("FAIL midreset_async: ctrl=%b values=%h expected all 0",
                     {busy, done, avm_read, id_ok, ts_ok, match, err_timeout}, {id_value, ts_value});
        end
        drop_ts  = 1'b0;
        late_req = 1'b1;
        @(negedge clock); #1;
        reset_n  = 1'b1;
        late_req = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clock); #1;
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        checks++;
        if (seen !== 1'b1 || id_value !== 32'h0000_0000 || match !== 1'b1) begin
            failures++;
            $display("FAIL late_valid_ignored: seen=%b id=%h match=%b expected 1/00000000/1", seen, id_value, match);
        end
        run_check(20, lat, seen, f1);
        checks++;
        if (seen !== 1'b1 || lat !== 5) begin
            failures++;
            $display("FAIL post_reset_check: seen=%b lat=%0d expected 1/5", seen, lat);
        end
        @(posedge clock); #1;
        checks++;
        if (match !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_match: got %b expected 1", match);
        end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_match();
        test_ts_mismatch();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
